// File: rtl/led_matrix_scan_driver.sv
// rtl/led_matrix_scan_driver.sv - 4x8 RGB LED matrix column scanner with serial colour shift-out
// Snapshots four column words per frame, shifts each out MSB first, latches, then lights that column.
module led_matrix_scan_driver #(
  parameter int CLK_DIV  = 4,
  parameter int COL_HOLD = 50000
) (
  input  logic        CLK_50M,
  input  logic        RST_N,
  input  logic        enable,
  input  logic [23:0] column_0,
  input  logic [23:0] column_1,
  input  logic [23:0] column_2,
  input  logic [23:0] column_3,
  output logic        sr_data,
  output logic        sr_clk,
  output logic        sr_latch,
  output logic [3:0]  col_sel,
  output logic        frame_done
);

  localparam int CNT_MAX = (CLK_DIV > COL_HOLD) ? CLK_DIV : COL_HOLD;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(COL_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_LATCH,
    S_HOLD
  } state_t;

  state_t          r_state;
  logic [1:0]      r_col;
  logic [CW-1:0]   r_cnt;
  logic [4:0]      r_bit;
  logic [23:0]     r_shift;
  logic [23:0]     r_buf [4];
  logic            r_sr_clk;
  logic            r_sr_latch;
  logic [3:0]      r_col_sel;
  logic            r_frame_done;

  logic [23:0]     w_load_word;
  logic            w_div_end;
  logic            w_hold_end;

  // Column 0 is loaded straight from the input in the same cycle it is snapshotted.
  assign w_load_word = (r_col == 2'd0) ? column_0 : r_buf[r_col];
  assign w_div_end   = (r_cnt == DIV_LAST);
  assign w_hold_end  = (r_cnt == HOLD_LAST);

  assign sr_data    = r_shift[23];
  assign sr_clk     = r_sr_clk;
  assign sr_latch   = r_sr_latch;
  assign col_sel    = r_col_sel;
  assign frame_done = r_frame_done;

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= S_IDLE;
      r_col        <= 2'd0;
      r_cnt        <= '0;
      r_bit        <= 5'd0;
      r_shift      <= 24'd0;
      r_sr_clk     <= 1'b0;
      r_sr_latch   <= 1'b0;
      r_col_sel    <= 4'b0000;
      r_frame_done <= 1'b0;
      for (int i = 0; i < 4; i++) r_buf[i] <= 24'd0;
    end else begin
      r_frame_done <= 1'b0;
      // Dropping enable wins over every state transition, including the frame_done wrap.
      if (!enable) begin
        r_state    <= S_IDLE;
        r_col      <= 2'd0;
        r_cnt      <= '0;
        r_bit      <= 5'd0;
        r_shift    <= 24'd0;
        r_sr_clk   <= 1'b0;
        r_sr_latch <= 1'b0;
        r_col_sel  <= 4'b0000;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_LOAD;
            r_col   <= 2'd0;
            r_cnt   <= '0;
          end
          S_LOAD: begin
            if (r_col == 2'd0) begin
              r_buf[0] <= column_0;
              r_buf[1] <= column_1;
              r_buf[2] <= column_2;
              r_buf[3] <= column_3;
            end
            r_shift   <= w_load_word;
            r_sr_clk  <= 1'b0;
            r_col_sel <= 4'b0000;
            r_cnt     <= '0;
            r_bit     <= 5'd0;
            r_state   <= S_SHIFT;
          end
          S_SHIFT: begin
            if (w_div_end) begin
              r_cnt <= '0;
              if (!r_sr_clk) begin
                r_sr_clk <= 1'b1;
              end else begin
                r_sr_clk <= 1'b0;
                if (r_bit == 5'd23) begin
                  r_shift    <= 24'd0;
                  r_sr_latch <= 1'b1;
                  r_state    <= S_LATCH;
                end else begin
                  r_bit   <= r_bit + 5'd1;
                  r_shift <= {r_shift[22:0], 1'b0};
                end
              end
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          S_LATCH: begin
            if (w_div_end) begin
              r_cnt      <= '0;
              r_sr_latch <= 1'b0;
              r_col_sel  <= 4'b0001 << r_col;
              r_state    <= S_HOLD;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          S_HOLD: begin
            if (w_hold_end) begin
              r_cnt        <= '0;
              r_col_sel    <= 4'b0000;
              r_col        <= r_col + 2'd1;
              r_frame_done <= (r_col == 2'd3);
              r_state      <= S_LOAD;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          default: begin
            r_state   <= S_IDLE;
            r_col_sel <= 4'b0000;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_matrix_scan_driver.sv
// tb/tb_led_matrix_scan_driver.sv - directed self-checking bench for led_matrix_scan_driver
// Small CLK_DIV/COL_HOLD keep frames short; a negedge monitor logs shifted words and timing.
module tb_led_matrix_scan_driver;

  localparam int CLK_DIV  = 2;
  localparam int COL_HOLD = 10;
  localparam int COL_PERIOD = 1 + 48 * CLK_DIV + CLK_DIV + COL_HOLD;

  logic        CLK_50M = 1'b0;
  logic        RST_N   = 1'b0;
  logic        enable  = 1'b1;
  logic [23:0] column_0 = 24'h200000;
  logic [23:0] column_1 = 24'h000000;
  logic [23:0] column_2 = 24'hFFFFFF;
  logic [23:0] column_3 = 24'h000000;
  logic        sr_data, sr_clk, sr_latch, frame_done;
  logic [3:0]  col_sel;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  led_matrix_scan_driver #(.CLK_DIV(CLK_DIV), .COL_HOLD(COL_HOLD)) dut (
    .CLK_50M(CLK_50M), .RST_N(RST_N), .enable(enable),
    .column_0(column_0), .column_1(column_1), .column_2(column_2), .column_3(column_3),
    .sr_data(sr_data), .sr_clk(sr_clk), .sr_latch(sr_latch),
    .col_sel(col_sel), .frame_done(frame_done)
  );

  always #10 CLK_50M = ~CLK_50M;
  always @(posedge CLK_50M) cyc++;

  logic [23:0] words [$];
  int          nbits [$];
  int          lat_w [$];
  logic [3:0]  sels [$];
  int          sel_cyc [$];
  int          holds [$];
  int          fd_cyc [$];
  int          fd_w [$];
  logic [23:0] cap = 24'd0;
  int          cap_cnt = 0, lat_start = 0, fd_start = 0, n_latch = 0, viol = 0;
  logic        p_clk = 1'b0, p_latch = 1'b0, p_fd = 1'b0;
  logic [3:0]  p_sel = 4'b0000;

  always @(negedge CLK_50M) begin
    if (!RST_N || !enable) cap_cnt = 0;
    else if (sr_clk && !p_clk) begin
      cap = {cap[22:0], sr_data};
      cap_cnt++;
    end
    if (sr_latch && !p_latch) begin
      words.push_back(cap); nbits.push_back(cap_cnt);
      cap_cnt = 0; lat_start = cyc; n_latch++;
    end
    if (!sr_latch && p_latch) lat_w.push_back(cyc - lat_start);
    if (col_sel != 4'b0000 && p_sel == 4'b0000) begin
      sels.push_back(col_sel); sel_cyc.push_back(cyc);
    end
    if (col_sel == 4'b0000 && p_sel != 4'b0000) holds.push_back(cyc - sel_cyc[$]);
    if (frame_done && !p_fd) begin fd_cyc.push_back(cyc); fd_start = cyc; end
    if (!frame_done && p_fd) fd_w.push_back(cyc - fd_start);
    if ($countones(col_sel) > 1 || (col_sel != 4'b0000 && (sr_latch || sr_clk))) viol++;
    p_clk = sr_clk; p_latch = sr_latch; p_sel = col_sel; p_fd = frame_done;
  end

  task automatic tick();
    @(negedge CLK_50M);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {sr_data, sr_clk, sr_latch, frame_done, col_sel};
  endfunction

  task automatic wait_sel(input string tag, input logic [3:0] v, input int bound);
    for (int i = 0; i < bound && col_sel !== v; i++) tick();
    chk(tag, 32'(col_sel), 32'(v));
  endtask

  initial begin
    int n, k, s, lat0;
    logic [23:0] exp_w [8];
    logic [3:0]  exp_s [4];
    exp_w = '{24'h200000, 24'h000000, 24'hFFFFFF, 24'h000000,
              24'hA5A5A5, 24'h000001, 24'h000000, 24'h800000};
    exp_s = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    for (int i = 0; i < 5; i++) begin
      tick();
      chk("reset_outputs", 32'(outs()), 32'h0);
    end

    // IDLE->LOAD on the first edge, then 1 LOAD cycle + CLK_DIV low cycles before sr_clk rises.
    RST_N = 1'b1;
    n = 0;
    do begin tick(); n++; end while (sr_clk !== 1'b1 && n < 50);
    chk("first_rise_latency", 32'(n), 32'(CLK_DIV + 2));

    for (int i = 0; i < 20; i++) tick();
    column_0 = 24'hA5A5A5; column_1 = 24'h000001; column_2 = 24'h000000; column_3 = 24'h800000;

    for (int i = 0; i < 1500 && fd_cyc.size() < 2; i++) tick();
    chk("frame_done_count", 32'(fd_cyc.size()), 32'd2);
    for (int i = 0; i < 8; i++) chk($sformatf("word%0d", i), 32'(words[i]), 32'(exp_w[i]));
    for (int i = 0; i < 8; i++) chk($sformatf("col_sel%0d", i), 32'(sels[i]), 32'(exp_s[i % 4]));
    chk("bits_per_word", 32'(nbits[0]), 32'd24);
    chk("latch_width", 32'(lat_w[0]), 32'(CLK_DIV));
    chk("hold_width_c0", 32'(holds[0]), 32'(COL_HOLD));
    chk("hold_width_c3", 32'(holds[7]), 32'(COL_HOLD));
    chk("column_period", 32'(sel_cyc[1] - sel_cyc[0]), 32'(COL_PERIOD));
    chk("frame_done_after_hold3", 32'(fd_cyc[0] - sel_cyc[3]), 32'(COL_HOLD));
    chk("frame_period", 32'(fd_cyc[1] - fd_cyc[0]), 32'(4 * COL_PERIOD));
    chk("frame_done_width", 32'(fd_w[0]), 32'd1);

    wait_sel("abort_reach_c0", 4'b0001, 500);
    wait_sel("abort_reach_c1_load", 4'b0000, 50);
    for (int i = 0; i < 30; i++) tick();
    lat0 = n_latch;
    enable = 1'b0;
    tick();
    chk("abort_outputs", 32'(outs()), 32'h0);
    for (int i = 0; i < 20; i++) tick();
    chk("abort_no_latch", 32'(n_latch), 32'(lat0));
    chk("abort_no_frame_done", 32'(fd_cyc.size()), 32'd2);
    chk("abort_idle_outputs", 32'(outs()), 32'h0);

    column_0 = 24'h5A0F3C;
    k = words.size(); s = sels.size();
    enable = 1'b1;
    for (int i = 0; i < 300 && sels.size() <= s; i++) tick();
    chk("reenable_first_sel", 32'(sels[s]), 32'h1);
    chk("reenable_snapshot", 32'(words[k]), 32'h5A0F3C);

    wait_sel("reach_c2_hold", 4'b0100, 600);
    tick(); tick(); tick();
    #3 RST_N = 1'b0;
    #1 chk("async_reset_outputs", 32'(outs()), 32'h0);
    tick(); tick(); tick();
    chk("reset_held_outputs", 32'(outs()), 32'h0);
    s = sels.size();
    RST_N = 1'b1;
    for (int i = 0; i < 300 && sels.size() <= s; i++) tick();
    chk("restart_first_sel", 32'(sels[s]), 32'h1);
    chk("blanking_onehot", 32'(viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
